// File: rtl/sat_pkg.sv
// Shared constants and types for the SAT local-search datapath.
// Holds problem sizing, occurrence-entry field offsets and the break-value FSM encoding.
// No logic; imported by the break-value calculator and its counter bank.
package sat_pkg;

    localparam int NSAT                          = 3;
    localparam int NSAT_BITS                     = 2;
    localparam int MAX_CLAUSES_PER_VARIABLE      = 20;
    localparam int MAX_CLAUSES_PER_VARIABLE_BITS = 5;
    localparam int VAR_BITS                      = 10;
    localparam int CLAUSE_BITS                   = 12;
    localparam int OCC_ADDR_BITS                 = 15;
    localparam int TC_BITS                       = 2;

    // Occurrence entry layout: {entry_valid, polarity, clause_idx}
    localparam int OCC_POL_BIT   = CLAUSE_BITS;
    localparam int OCC_VALID_BIT = CLAUSE_BITS + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } bvc_state_t;

endpackage

// File: rtl/bvc_counter_bank.sv
// Bank of NSAT saturating break-value counters with synchronous clear and indexed increment.
// Latency: increment visible the cycle after inc_i; clear has priority over increment.
// No backpressure; one increment per cycle. Ports: clk, reset, clr_i, inc_i, inc_idx_i, cnt_o (packed).
module bvc_counter_bank #(
    parameter int NSAT      = sat_pkg::NSAT,
    parameter int NSAT_BITS = sat_pkg::NSAT_BITS,
    parameter int CNT_BITS  = sat_pkg::MAX_CLAUSES_PER_VARIABLE_BITS
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clr_i,
    input  logic                     inc_i,
    input  logic [NSAT_BITS-1:0]     inc_idx_i,
    output logic [NSAT*CNT_BITS-1:0] cnt_o
);

    logic [NSAT*CNT_BITS-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            for (int i = 0; i < NSAT; i++) begin
                // Saturate at all-ones rather than wrapping back to zero
                if (NSAT_BITS'(i) == inc_idx_i &&
                    cnt_q[i*CNT_BITS +: CNT_BITS] != {CNT_BITS{1'b1}}) begin
                    cnt_d[i*CNT_BITS +: CNT_BITS] = cnt_q[i*CNT_BITS +: CNT_BITS] + CNT_BITS'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/break_value_calculator.sv
// Computes the break value of each candidate variable of an unsatisfied clause.
// Latency: done_o at T+Nv*M+3 after start (T+1 when no candidate valid); optional
// macro BVC_EARLY_EXIT_EN stops a candidate's list at its first invalid entry (latency
// then data-dependent, same upper bound). start_i is ignored while busy_o, no queuing.
// Ports: start/var_* inputs, busy/done/break_value outputs, occ and tc synchronous read ports.
module break_value_calculator #(
    parameter int NSAT                          = sat_pkg::NSAT,
    parameter int NSAT_BITS                     = sat_pkg::NSAT_BITS,
    parameter int MAX_CLAUSES_PER_VARIABLE      = sat_pkg::MAX_CLAUSES_PER_VARIABLE,
    parameter int MAX_CLAUSES_PER_VARIABLE_BITS = sat_pkg::MAX_CLAUSES_PER_VARIABLE_BITS,
    parameter int VAR_BITS                      = sat_pkg::VAR_BITS,
    parameter int CLAUSE_BITS                   = sat_pkg::CLAUSE_BITS,
    parameter int OCC_ADDR_BITS                 = sat_pkg::OCC_ADDR_BITS,
    parameter int TC_BITS                       = sat_pkg::TC_BITS
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic                                      start_i,
    input  logic [NSAT*VAR_BITS-1:0]                  var_ids_i,
    input  logic [NSAT-1:0]                           var_values_i,
    input  logic [NSAT-1:0]                           var_valid_i,
    output logic                                      busy_o,
    output logic                                      done_o,
    output logic [NSAT*MAX_CLAUSES_PER_VARIABLE_BITS-1:0] break_values_o,
    output logic [NSAT-1:0]                           break_value_valid_o,
    output logic                                      occ_rd_o,
    output logic [OCC_ADDR_BITS-1:0]                  occ_addr_o,
    input  logic [CLAUSE_BITS+1:0]                    occ_data_i,
    output logic                                      tc_rd_o,
    output logic [CLAUSE_BITS-1:0]                    tc_addr_o,
    input  logic [TC_BITS-1:0]                        tc_data_i
);
    import sat_pkg::*;

    localparam int MB = MAX_CLAUSES_PER_VARIABLE_BITS;

    bvc_state_t                state_q, state_d;
    logic [NSAT*VAR_BITS-1:0]  ids_q, ids_d;
    logic [NSAT-1:0]           vals_q, vals_d;
    logic [NSAT-1:0]           vld_q, vld_d;
    logic [NSAT_BITS-1:0]      cand_q, cand_d;
    logic [MB-1:0]             slot_q, slot_d;
    logic                      drain_q, drain_d;

    // Pipeline tags: stage B holds the returning occ read, stage C the returning tc read
    logic                      b_vld_q, b_vld_d;
    logic [NSAT_BITS-1:0]      b_cand_q;
    logic                      c_vld_q;
    logic [NSAT_BITS-1:0]      c_cand_q;

    logic                      clr;
    logic                      first_found, next_found;
    logic [NSAT_BITS-1:0]      first_idx, next_idx;
    logic                      occ_valid, occ_pol, lit_true, list_end;
    logic [VAR_BITS-1:0]       cur_var;

    // Lowest valid candidate at start, and the next valid candidate above the current one
    always_comb begin
        first_found = 1'b0;
        first_idx   = '0;
        next_found  = 1'b0;
        next_idx    = '0;
        for (int i = NSAT - 1; i >= 0; i--) begin
            if (var_valid_i[i]) begin
                first_found = 1'b1;
                first_idx   = NSAT_BITS'(i);
            end
            if (vld_q[i] && NSAT_BITS'(i) > cand_q) begin
                next_found = 1'b1;
                next_idx   = NSAT_BITS'(i);
            end
        end
    end

    assign occ_valid = occ_data_i[OCC_VALID_BIT];
    assign occ_pol   = occ_data_i[OCC_POL_BIT];
    assign lit_true  = (occ_pol == vals_q[b_cand_q]);

`ifdef BVC_EARLY_EXIT_EN
    // An invalid entry for the candidate still being issued terminates its list;
    // the read issued in this same cycle belongs to that candidate and is dropped.
    assign list_end = b_vld_q && !occ_valid && (state_q == SCAN) && (b_cand_q == cand_q);
`else
    assign list_end = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        ids_d    = ids_q;
        vals_d   = vals_q;
        vld_d    = vld_q;
        cand_d   = cand_q;
        slot_d   = slot_q;
        drain_d  = drain_q;
        clr      = 1'b0;
        done_o   = 1'b0;
        occ_rd_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    ids_d   = var_ids_i;
                    vals_d  = var_values_i;
                    vld_d   = var_valid_i;
                    clr     = 1'b1;
                    cand_d  = first_idx;
                    slot_d  = '0;
                    drain_d = 1'b0;
                    state_d = first_found ? SCAN : DONE;
                end
            end
            SCAN: begin
                occ_rd_o = 1'b1;
                if (list_end || slot_q == MB'(MAX_CLAUSES_PER_VARIABLE - 1)) begin
                    if (next_found) begin
                        cand_d = next_idx;
                        slot_d = '0;
                    end else begin
                        state_d = DRAIN;
                    end
                end else begin
                    slot_d = slot_q + MB'(1);
                end
            end
            DRAIN: begin
                drain_d = 1'b1;
                if (drain_q) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done_o  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign b_vld_d = occ_rd_o && !list_end;

    assign cur_var    = ids_q[int'(cand_q)*VAR_BITS +: VAR_BITS];
    assign occ_addr_o = occ_rd_o ? (OCC_ADDR_BITS'(cur_var) * OCC_ADDR_BITS'(MAX_CLAUSES_PER_VARIABLE)
                                    + OCC_ADDR_BITS'(slot_q)) : '0;

    // Only currently-true literals can break a clause, so only those fetch a true-count
    assign tc_rd_o   = b_vld_q && occ_valid && lit_true;
    assign tc_addr_o = tc_rd_o ? occ_data_i[CLAUSE_BITS-1:0] : '0;

    assign busy_o              = (state_q != IDLE);
    assign break_value_valid_o = vld_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            ids_q    <= '0;
            vals_q   <= '0;
            vld_q    <= '0;
            cand_q   <= '0;
            slot_q   <= '0;
            drain_q  <= 1'b0;
            b_vld_q  <= 1'b0;
            b_cand_q <= '0;
            c_vld_q  <= 1'b0;
            c_cand_q <= '0;
        end else begin
            state_q  <= state_d;
            ids_q    <= ids_d;
            vals_q   <= vals_d;
            vld_q    <= vld_d;
            cand_q   <= cand_d;
            slot_q   <= slot_d;
            drain_q  <= drain_d;
            b_vld_q  <= b_vld_d;
            b_cand_q <= cand_q;
            c_vld_q  <= tc_rd_o;
            c_cand_q <= b_cand_q;
        end
    end

    // A true-count of 0 on a true literal is inconsistent memory and is not counted
    bvc_counter_bank #(
        .NSAT      (NSAT),
        .NSAT_BITS (NSAT_BITS),
        .CNT_BITS  (MB)
    ) u_cnt (
        .clk       (clk),
        .reset     (reset),
        .clr_i     (clr),
        .inc_i     (c_vld_q && tc_data_i == TC_BITS'(1)),
        .inc_idx_i (c_cand_q),
        .cnt_o     (break_values_o)
    );

endmodule

// File: tb/tb_break_value_calculator.sv
// Self-checking bench for break_value_calculator with NSAT=3, M=4.
// Behavioural occurrence/true-count memories answer one cycle after each strobe.
// Expected results are queued at launch and compared when done_o appears.
module tb_break_value_calculator;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_i;
    logic [29:0] var_ids_i;
    logic [2:0]  var_values_i;
    logic [2:0]  var_valid_i;
    logic        busy_o, done_o;
    logic [8:0]  break_values_o;
    logic [2:0]  break_value_valid_o;
    logic        occ_rd_o;
    logic [14:0] occ_addr_o;
    logic [13:0] occ_data_i;
    logic        tc_rd_o;
    logic [11:0] tc_addr_o;
    logic [1:0]  tc_data_i;

    always #5 clk = ~clk;

    break_value_calculator #(
        .MAX_CLAUSES_PER_VARIABLE      (4),
        .MAX_CLAUSES_PER_VARIABLE_BITS (3)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .start_i             (start_i),
        .var_ids_i           (var_ids_i),
        .var_values_i        (var_values_i),
        .var_valid_i         (var_valid_i),
        .busy_o              (busy_o),
        .done_o              (done_o),
        .break_values_o      (break_values_o),
        .break_value_valid_o (break_value_valid_o),
        .occ_rd_o            (occ_rd_o),
        .occ_addr_o          (occ_addr_o),
        .occ_data_i          (occ_data_i),
        .tc_rd_o             (tc_rd_o),
        .tc_addr_o           (tc_addr_o),
        .tc_data_i           (tc_data_i)
    );

    logic [13:0] occ_mem [0:32767];
    logic [1:0]  tc_mem  [0:4095];
    int          occ_rd_cnt = 0;
    int          tc_rd_cnt  = 0;

    // Synchronous-read memories; random junk when not strobed so stale data is never trusted
    always @(posedge clk) begin
        occ_data_i <= occ_rd_o ? occ_mem[occ_addr_o] : 14'($urandom);
        tc_data_i  <= tc_rd_o  ? tc_mem[tc_addr_o]   : 2'($urandom);
        if (occ_rd_o) occ_rd_cnt <= occ_rd_cnt + 1;
        if (tc_rd_o)  tc_rd_cnt  <= tc_rd_cnt + 1;
    end

    typedef struct {
        logic [8:0] bv;
        logic [2:0] vld;
        int         lat;
    } exp_t;
    exp_t sb[$];

    int chk_cnt  = 0;
    int pass_cnt = 0;

    function automatic logic [13:0] ent(input logic v, input logic p, input int cl);
        return {v, p, 12'(cl)};
    endfunction

    task automatic launch(input logic [29:0] ids, input logic [2:0] vals, input logic [2:0] vld,
                          input logic [8:0] ebv, input int elat);
        exp_t e;
        @(negedge clk);
        var_ids_i    = ids;
        var_values_i = vals;
        var_valid_i  = vld;
        start_i      = 1'b1;
        e.bv = ebv; e.vld = vld; e.lat = elat;
        sb.push_back(e);
        @(posedge clk);
    endtask

    // Returns cycles from accepted start to done_o, or -1 if it never came
    task automatic wait_done(output int lat);
        lat = -1;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (k == 1) begin
                start_i      = 1'b0;
                var_ids_i    = 30'($urandom);
                var_values_i = 3'($urandom);
                var_valid_i  = 3'($urandom);
            end
            if (done_o) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start_i = 1'b0;
        var_ids_i = '0; var_values_i = '0; var_valid_i = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_cnt++;
        if ({busy_o, done_o, occ_rd_o, tc_rd_o} !== 4'b0000)
            $display("FAIL reset_ctrl: got %b expected 0000", {busy_o, done_o, occ_rd_o, tc_rd_o});
        else pass_cnt++;
        chk_cnt++;
        if (break_values_o !== 9'd0 || break_value_valid_o !== 3'd0)
            $display("FAIL reset_vals: got bv=%h vld=%b expected 0", break_values_o, break_value_valid_o);
        else pass_cnt++;
        chk_cnt++;
        if (occ_addr_o !== 15'd0 || tc_addr_o !== 12'd0)
            $display("FAIL reset_addr: got occ=%0d tc=%0d expected 0", occ_addr_o, tc_addr_o);
        else pass_cnt++;
        reset = 1'b0;
    endtask

    task automatic test_single_break();
        int lat; exp_t e;
        occ_mem[20] = ent(1, 0, 50);  tc_mem[50]  = 2'd1;
        occ_mem[36] = ent(1, 0, 100); tc_mem[100] = 2'd1;
        occ_mem[8]  = ent(1, 1, 200); tc_mem[200] = 2'd2;
        occ_mem[9]  = ent(1, 1, 201); tc_mem[201] = 2'd0;
        launch({10'd2, 10'd9, 10'd5}, 3'b101, 3'b111, {3'd0, 3'd1, 3'd0}, 15);
        wait_done(lat);
        e = sb.pop_front();
        chk_cnt++;
        if (lat !== e.lat) $display("FAIL single_lat: got %0d expected %0d", lat, e.lat);
        else pass_cnt++;
        chk_cnt++;
        if (break_values_o !== e.bv) $display("FAIL single_bv: got %h expected %h", break_values_o, e.bv);
        else pass_cnt++;
        chk_cnt++;
        if (break_value_valid_o !== e.vld)
            $display("FAIL single_vld: got %b expected %b", break_value_valid_o, e.vld);
        else pass_cnt++;
        @(negedge clk);
        chk_cnt++;
        if (done_o !== 1'b0 || busy_o !== 1'b0)
            $display("FAIL single_pulse: got done=%b busy=%b expected 0 0", done_o, busy_o);
        else pass_cnt++;
    endtask

    task automatic test_polarity();
        int lat, occ0, tc0; exp_t e;
        occ_mem[28] = ent(1, 0, 300); tc_mem[300] = 2'd1;
        occ_mem[29] = ent(1, 0, 301); tc_mem[301] = 2'd1;
        occ0 = occ_rd_cnt; tc0 = tc_rd_cnt;
        launch({10'd0, 10'd0, 10'd7}, 3'b001, 3'b001, 9'd0, 7);
        wait_done(lat);
        e = sb.pop_front();
        chk_cnt++;
        if (lat !== e.lat || break_values_o !== e.bv)
            $display("FAIL polarity_res: got lat=%0d bv=%h expected lat=%0d bv=%h", lat, break_values_o, e.lat, e.bv);
        else pass_cnt++;
        chk_cnt++;
        if (tc_rd_cnt - tc0 !== 0 || occ_rd_cnt - occ0 !== 4)
            $display("FAIL polarity_reads: got tc=%0d occ=%0d expected tc=0 occ=4", tc_rd_cnt - tc0, occ_rd_cnt - occ0);
        else pass_cnt++;
    endtask

    task automatic setup_mixed();
        for (int s = 0; s < 4; s++) begin
            occ_mem[44+s] = ent(1, 0, 400+s); tc_mem[400+s] = 2'd1;
            occ_mem[48+s] = ent(1, 1, 420+s); tc_mem[420+s] = 2'd1;
            occ_mem[52+s] = ent(1, 1, 410+s); tc_mem[410+s] = 2'd1;
        end
    endtask

    task automatic test_mixed_valid();
        int lat, occ0, tc0; exp_t e;
        setup_mixed();
        occ0 = occ_rd_cnt; tc0 = tc_rd_cnt;
        launch({10'd13, 10'd12, 10'd11}, 3'b110, 3'b101, {3'd4, 3'd0, 3'd4}, 11);
        wait_done(lat);
        e = sb.pop_front();
        chk_cnt++;
        if (lat !== e.lat) $display("FAIL mixed_lat: got %0d expected %0d", lat, e.lat);
        else pass_cnt++;
        chk_cnt++;
        if (break_values_o !== e.bv || break_value_valid_o !== e.vld)
            $display("FAIL mixed_res: got bv=%h vld=%b expected bv=%h vld=%b", break_values_o, break_value_valid_o, e.bv, e.vld);
        else pass_cnt++;
        chk_cnt++;
        if (occ_rd_cnt - occ0 !== 8 || tc_rd_cnt - tc0 !== 8)
            $display("FAIL mixed_reads: got occ=%0d tc=%0d expected 8 8", occ_rd_cnt - occ0, tc_rd_cnt - tc0);
        else pass_cnt++;
        repeat (5) @(negedge clk);
        chk_cnt++;
        if (break_values_o !== e.bv || break_value_valid_o !== e.vld)
            $display("FAIL mixed_hold: got bv=%h vld=%b expected bv=%h vld=%b", break_values_o, break_value_valid_o, e.bv, e.vld);
        else pass_cnt++;
    endtask

    task automatic test_nv_zero();
        int lat, occ0; exp_t e;
        occ0 = occ_rd_cnt;
        launch({10'd13, 10'd12, 10'd11}, 3'b111, 3'b000, 9'd0, 1);
        wait_done(lat);
        e = sb.pop_front();
        chk_cnt++;
        if (lat !== e.lat) $display("FAIL nv0_lat: got %0d expected %0d", lat, e.lat);
        else pass_cnt++;
        chk_cnt++;
        if (break_values_o !== e.bv || break_value_valid_o !== e.vld)
            $display("FAIL nv0_res: got bv=%h vld=%b expected 0 0", break_values_o, break_value_valid_o);
        else pass_cnt++;
        chk_cnt++;
        if (occ_rd_cnt - occ0 !== 0) $display("FAIL nv0_occ: got %0d reads expected 0", occ_rd_cnt - occ0);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        setup_mixed();
        launch({10'd13, 10'd12, 10'd11}, 3'b110, 3'b101, {3'd4, 3'd0, 3'd4}, 11);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k == 1) start_i = 1'b0;
            if (k == 3) reset = 1'b1;
        end
        reset = 1'b0;
        void'(sb.pop_front());
        chk_cnt++;
        if ({busy_o, occ_rd_o, tc_rd_o, done_o} !== 4'b0000)
            $display("FAIL midreset_ctrl: got %b expected 0000", {busy_o, occ_rd_o, tc_rd_o, done_o});
        else pass_cnt++;
        chk_cnt++;
        if (break_values_o !== 9'd0) $display("FAIL midreset_bv: got %h expected 0", break_values_o);
        else pass_cnt++;
    endtask

    task automatic test_busy_early_exit();
        int lat, extra; exp_t e;
        occ_mem[80] = ent(1, 1, 500); tc_mem[500] = 2'd1;
        occ_mem[84] = ent(1, 0, 501); tc_mem[501] = 2'd1;
        occ_mem[88] = ent(1, 1, 502); tc_mem[502] = 2'd1;
        for (int s = 1; s < 4; s++) begin
            occ_mem[80+s] = ent(0, 1, 503); occ_mem[84+s] = ent(0, 0, 503); occ_mem[88+s] = ent(0, 1, 503);
        end
        tc_mem[503] = 2'd1;
        launch({10'd22, 10'd21, 10'd20}, 3'b101, 3'b111, {3'd1, 3'd1, 3'd1}, 15);
        lat = -1;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            start_i = (k == 2);
            if (k == 2) var_valid_i = 3'b010;
            if (done_o) begin
                lat = k;
                break;
            end
        end
        e = sb.pop_front();
`ifdef BVC_EARLY_EXIT_EN
        chk_cnt++;
        if (lat < 1 || lat >= e.lat) $display("FAIL early_lat: got %0d expected below %0d", lat, e.lat);
        else pass_cnt++;
`else
        chk_cnt++;
        if (lat !== e.lat) $display("FAIL early_lat: got %0d expected %0d", lat, e.lat);
        else pass_cnt++;
`endif
        chk_cnt++;
        if (break_values_o !== e.bv || break_value_valid_o !== e.vld)
            $display("FAIL early_res: got bv=%h vld=%b expected bv=%h vld=%b", break_values_o, break_value_valid_o, e.bv, e.vld);
        else pass_cnt++;
        extra = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done_o || busy_o) extra++;
        end
        chk_cnt++;
        if (extra !== 0) $display("FAIL busy_ignored: got %0d busy/done cycles after done expected 0", extra);
        else pass_cnt++;
    endtask

    initial begin
        for (int i = 0; i < 32768; i++) occ_mem[i] = '0;
        for (int i = 0; i < 4096; i++)  tc_mem[i]  = '0;
        test_reset();
        test_single_break();
        test_polarity();
        test_mixed_valid();
        test_nv_zero();
        test_reset_mid();
        test_single_break();
        test_busy_early_exit();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/break_value_calculator.md
Name: break_value_calculator

Overview:
- Upstream stage of the heuristic selector.
- Given the NSAT candidate variables of the chosen unsatisfied clause, it computes each candidate's break value.
- Break value = number of clauses that currently have exactly one true literal, where that literal belongs to the candidate.
- It walks each candidate's occurrence list in the occurrence memory and reads clause true-counts from the true-count memory. Both are external synchronous read ports.
- It presents packed break values plus a valid vector in the format the selector consumes.

Parameters:
- NSAT, 3, literals per clause / number of candidates.
- NSAT_BITS, 2, width of a candidate index.
- MAX_CLAUSES_PER_VARIABLE, 20, occurrence slots per variable (M).
- MAX_CLAUSES_PER_VARIABLE_BITS, 5, break value width; must hold M.
- VAR_BITS, 10, variable index width.
- CLAUSE_BITS, 12, clause index width.
- OCC_ADDR_BITS, 15, occurrence memory address width.
- TC_BITS, 2, clause true-count width (0..NSAT).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- start_i  in  1  launch a computation; honoured only in IDLE.
- var_ids_i  in  NSAT*VAR_BITS  candidate variable indices, packed (slot 0 in the LSBs).
- var_values_i  in  NSAT  current assignment of each candidate.
- var_valid_i  in  NSAT  candidate present and legal to flip.
- busy_o  out  1  high in any state other than IDLE.
- done_o  out  1  single-cycle pulse when results are valid.
- break_values_o  out  NSAT*MAX_CLAUSES_PER_VARIABLE_BITS  packed break values.
- break_value_valid_o  out  NSAT  latched copy of var_valid_i.
- occ_rd_o  out  1  occurrence memory read strobe.
- occ_addr_o  out  OCC_ADDR_BITS  address = var_id*M + slot.
- occ_data_i  in  CLAUSE_BITS+2  occurrence entry {entry_valid, polarity, clause_idx}; valid 1 cycle after the strobe.
- tc_rd_o  out  1  true-count memory read strobe.
- tc_addr_o  out  CLAUSE_BITS  clause index.
- tc_data_i  in  TC_BITS  clause true-count; valid 1 cycle after the strobe.

Behaviour:
- Reset values: busy_o=0, done_o=0, break_values_o=0, break_value_valid_o=0, occ_rd_o=0, tc_rd_o=0, addresses=0. State goes to IDLE.
- Reset mid-operation aborts the computation. Any returning read data is ignored.
- FSM states: IDLE, SCAN, DRAIN, DONE.
  - IDLE: on start_i, latch the inputs and clear the counters. Let Nv = popcount(var_valid_i). Go to SCAN if Nv>0, otherwise go to DONE.
  - SCAN: issue one occ read per cycle, back-to-back over the valid candidates in index order, slots 0..M-1 each. Invalid candidates are skipped with zero cycles. After the last issue, go to DRAIN.
  - DRAIN: exactly 2 cycles to flush the pipeline.
  - DONE: one cycle with done_o=1, then IDLE.
- Pipeline, with the owning candidate index tagged through it:
  - Stage A: issue the occ read.
  - Stage B: occ data returns. If entry_valid and polarity==var_value (the literal is currently true), assert tc_rd_o with tc_addr_o=clause_idx.
  - Stage C: tc data returns. If tc_data_i==1, increment that candidate's counter.
- Latency, with start accepted at cycle T: done_o is asserted at T+Nv*M+3. When Nv=0, done_o is asserted at T+1 and all break values are 0.
- Counters saturate at 2^MAX_CLAUSES_PER_VARIABLE_BITS-1. Counters of invalid candidates stay 0.
- Outputs hold stable from DONE until the next accepted start.
- start_i while busy is ignored; no queuing.
- A tc_data_i of 0 on a true literal indicates memory inconsistency. It is not counted.

Optional Feature:
- Macro: BVC_EARLY_EXIT_EN.
- When defined: an entry with entry_valid=0 in stage B ends that candidate's list. The one read already issued for the same candidate is discarded, and issue jumps to the next valid candidate. done_o timing becomes data-dependent, with T+Nv*M+3 as the upper bound.
- When undefined: all M slots are always scanned, invalid entries are ignored, and latency is exact.

Decomposition:
- Shared package sat_pkg holds:
  - NSAT, NSAT_BITS, MAX_CLAUSES_PER_VARIABLE(_BITS), VAR_BITS, CLAUSE_BITS;
  - occurrence entry field offsets (OCC_VALID_BIT, OCC_POL_BIT);
  - the FSM state enum.
- One natural sub-module: bvc_counter_bank, holding the NSAT saturating counters with clear and indexed increment.

Test Plan:
- All bench cases use NSAT=3, M=4.
- Single break: var ids {5,9,2} all valid, values {1,0,1}. Var 9 has a positive-polarity... (see below).
  - Precisely: var 9 (value 0) has one entry with polarity 0 pointing at a clause with tc=1.
  - Expected: break_values {0,1,0}, valid=3'b111, done_o at T+15.
- Polarity filter: a var with value 1 has two entries with polarity 0 on clauses with tc=1. Expected: break value 0 and no tc_rd_o for those entries.
- Mixed valid: var_valid_i=3'b101 with 4 breaking entries per valid var. Expected: {4,0,4}, valid=3'b101, done_o at T+11.
- Nv=0: var_valid_i=0. Expected: done_o at T+1, all outputs 0, no occ_rd_o ever asserted.
- Reset mid-operation: assert reset in the 3rd SCAN cycle. Expected: next cycle busy_o=0 and strobes 0. A new start then gives correct results with no carry-over.
- Busy and early exit: start_i pulsed during SCAN is ignored. With BVC_EARLY_EXIT_EN and entry 1 invalid for all three vars, done_o arrives before T+15 and the results equal the non-macro results.
